gol_gen_scheduler: RTL and testbench

Generation scheduler for the 16x16 cellular-automaton grid. Replaces the free-running evolution clock with a single-cycle `evolve` enable in the 50 MHz domain. It sequences run, pause, single-step and pattern-load commands. Every generation update lands at a VGA frame boundary, so the display never shows a half-updated grid. It sits between the board switches/buttons, the VGA timing driver and the cell array.

---
 rtl/gol_pkg.sv | 14 +
 rtl/gol_tick_timer.sv | 27 ++
 rtl/gol_gen_scheduler.sv | 103 ++++++++++
 tb/tb_gol_gen_scheduler.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/gol_pkg.sv
// Shared types and constants for the 16x16 cellular-automaton generation logic.
package gol_pkg;

    typedef enum logic [1:0] {
        PAUSE = 2'd0,
        RUN   = 2'd1,
        LOAD  = 2'd2
    } sched_state_t;

    localparam int PERIOD_DEFAULT = 390625;
    localparam int L  = 16;
    localparam int L2 = L * L;

endpackage

// File: rtl/gol_tick_timer.sv
// Generation period counter. It ticks combinationally once count reaches period-1
// and clears whenever it is disabled.
module gol_tick_timer #(
    parameter int PERIOD_W = 30
) (
    input  logic                clk_in,
    input  logic                rst_n,
    input  logic                enable,
    input  logic [PERIOD_W-1:0] period,
    output logic                tick
);

    logic [PERIOD_W-1:0] count;

    // Using >= instead of == lets a shortened period take effect at once.
    assign tick = enable && (count >= period - PERIOD_W'(1));

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n)
            count <= '0;
        else if (!enable || tick)
            count <= '0;
        else
            count <= count + PERIOD_W'(1);
    end

endmodule

// File: rtl/gol_gen_scheduler.sv
// Generation scheduler: run/pause/step/load sequencing, with every generation
// update aligned to a VGA frame boundary.
module gol_gen_scheduler #(
    parameter int PERIOD_DEFAULT = gol_pkg::PERIOD_DEFAULT,
    parameter int PERIOD_W       = 30,
    parameter int GEN_W          = 16,
    parameter int LOAD_CYCLES    = 2
) (
    input  logic             clk_in,
    input  logic             rst_n,
    input  logic [2:0]       speed,
    input  logic             run_sw,
    input  logic             step_btn,
    input  logic             load_btn,
    input  logic             frame_start,
    output logic             evolve,
    output logic             set_state,
    output logic [GEN_W-1:0] gen_count,
    output logic             overrun,
    output logic [1:0]       sched_state
);
    import gol_pkg::*;

    localparam int LC_W = $clog2(LOAD_CYCLES + 1);

    sched_state_t        state, state_nxt;
    logic [LC_W-1:0]     load_cnt;
    logic [PERIOD_W-1:0] period;
    logic step_prev, load_prev, pending, tick;
    logic step_edge, load_edge, step_ok, tick_ok, pend_now, fire;

    assign period      = PERIOD_W'(PERIOD_DEFAULT) << speed;
    assign step_edge   = step_btn & ~step_prev;
    assign load_edge   = load_btn & ~load_prev;
    assign sched_state = state;

    gol_tick_timer #(.PERIOD_W(PERIOD_W)) u_timer (
        .clk_in (clk_in),
        .rst_n  (rst_n),
        .enable (state == RUN),
        .period (period),
        .tick   (tick)
    );

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n)
            state <= PAUSE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (load_edge)
            state_nxt = LOAD;
        else begin
            case (state)
                PAUSE:   if (run_sw) state_nxt = RUN;
                RUN:     if (!run_sw) state_nxt = PAUSE;
                LOAD:    if (load_cnt == LC_W'(LOAD_CYCLES - 1)) state_nxt = PAUSE;
                default: state_nxt = PAUSE;
            endcase
        end
    end

    // A request only counts when no higher-priority event changes state this cycle.
    assign step_ok  = step_edge && (state == PAUSE) && (state_nxt == PAUSE);
    assign tick_ok  = tick && (state == RUN) && (state_nxt == RUN);
    assign pend_now = pending | step_ok | tick_ok;
    assign fire     = frame_start && pend_now && !evolve;

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            step_prev <= 1'b1;
            load_prev <= 1'b1;
            load_cnt  <= '0;
            set_state <= 1'b0;
            pending   <= 1'b0;
            evolve    <= 1'b0;
            overrun   <= 1'b0;
            gen_count <= '0;
        end else begin
            step_prev <= step_btn;
            load_prev <= load_btn;
            set_state <= (state_nxt == LOAD);
            load_cnt  <= (state == LOAD && !load_edge) ? load_cnt + LC_W'(1) : '0;
            if (load_edge) begin
                pending   <= 1'b0;
                evolve    <= 1'b0;
                overrun   <= 1'b0;
                gen_count <= '0;
            end else begin
                evolve  <= fire;
                pending <= pend_now & ~fire;
                if (tick_ok && pending)
                    overrun <= 1'b1;
                if (fire)
                    gen_count <= gen_count + GEN_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_gol_gen_scheduler.sv
// Directed bench for gol_gen_scheduler with a short base period and 20-cycle frames.
module tb_gol_gen_scheduler;

    logic        clk_in = 1'b0;
    logic        rst_n = 1'b0;
    logic [2:0]  speed = 3'd0;
    logic        run_sw = 1'b0;
    logic        step_btn = 1'b0;
    logic        load_btn = 1'b0;
    logic        frame_start = 1'b0;
    logic        evolve;
    logic        set_state;
    logic [15:0] gen_count;
    logic        overrun;
    logic [1:0]  sched_state;

    int n_cmp = 0;
    int n_bad = 0;

    gol_gen_scheduler #(
        .PERIOD_DEFAULT (4),
        .PERIOD_W       (30),
        .GEN_W          (16),
        .LOAD_CYCLES    (2)
    ) dut (
        .clk_in      (clk_in),
        .rst_n       (rst_n),
        .speed       (speed),
        .run_sw      (run_sw),
        .step_btn    (step_btn),
        .load_btn    (load_btn),
        .frame_start (frame_start),
        .evolve      (evolve),
        .set_state   (set_state),
        .gen_count   (gen_count),
        .overrun     (overrun),
        .sched_state (sched_state)
    );

    always #5 clk_in = ~clk_in;

    task automatic clk1();
        @(posedge clk_in);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; run_sw = 1'b0; step_btn = 1'b0; load_btn = 1'b0;
        frame_start = 1'b0; speed = 3'd0;
        clk1();
        clk1();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        #1;
        n_cmp++; if (evolve !== 1'b0) begin n_bad++; $display("FAIL reset_evolve got %b want 0", evolve); end
        n_cmp++; if (set_state !== 1'b0) begin n_bad++; $display("FAIL reset_set_state got %b want 0", set_state); end
        n_cmp++; if (gen_count !== 16'h0) begin n_bad++; $display("FAIL reset_gen got %h want 0", gen_count); end
        n_cmp++; if (overrun !== 1'b0) begin n_bad++; $display("FAIL reset_overrun got %b want 0", overrun); end
        n_cmp++; if (sched_state !== 2'd0) begin n_bad++; $display("FAIL reset_state got %0d want 0", sched_state); end
    endtask

    task automatic test_run();
        do_reset();
        for (int c = 0; c <= 41; c++) begin
            n_cmp++;
            if (evolve !== (c == 20 || c == 40)) begin
                n_bad++; $display("FAIL run_evolve c=%0d got %b want %b", c, evolve, (c == 20 || c == 40));
            end
            if (c == 8) begin
                n_cmp++; if (overrun !== 1'b0) begin n_bad++; $display("FAIL run_overrun_early got %b want 0", overrun); end
            end
            if (c == 9) begin
                n_cmp++; if (overrun !== 1'b1) begin n_bad++; $display("FAIL run_overrun got %b want 1", overrun); end
            end
            if (c == 2) begin
                n_cmp++; if (sched_state !== 2'd1) begin n_bad++; $display("FAIL run_state got %0d want 1", sched_state); end
            end
            if (c == 20) begin
                n_cmp++; if (gen_count !== 16'd1) begin n_bad++; $display("FAIL run_gen1 got %0d want 1", gen_count); end
            end
            if (c == 40) begin
                n_cmp++; if (gen_count !== 16'd2) begin n_bad++; $display("FAIL run_gen2 got %0d want 2", gen_count); end
            end
            run_sw = 1'b1;
            frame_start = (c == 19 || c == 39);
            clk1();
        end
    endtask

    task automatic test_step();
        do_reset();
        for (int c = 0; c <= 46; c++) begin
            n_cmp++;
            if (evolve !== (c == 21)) begin
                n_bad++; $display("FAIL step_evolve c=%0d got %b want %b", c, evolve, (c == 21));
            end
            if (c == 21 || c == 46) begin
                n_cmp++; if (gen_count !== 16'd1) begin n_bad++; $display("FAIL step_gen c=%0d got %0d want 1", c, gen_count); end
            end
            run_sw = 1'b0;
            step_btn = (c == 3 || c == 22);
            frame_start = (c == 20);
            clk1();
        end
    endtask

    task automatic test_wrap();
        do_reset();
        for (int c = 0; c <= 21; c++) begin
            if (c == 0) force dut.gen_count = 16'hFFFF;
            if (c == 1) release dut.gen_count;
            if (c == 19) begin
                n_cmp++; if (gen_count !== 16'hFFFF) begin n_bad++; $display("FAIL wrap_pre got %h want ffff", gen_count); end
            end
            if (c == 20) begin
                n_cmp++; if (evolve !== 1'b1) begin n_bad++; $display("FAIL wrap_evolve got %b want 1", evolve); end
                n_cmp++; if (gen_count !== 16'h0000) begin n_bad++; $display("FAIL wrap_gen got %h want 0000", gen_count); end
            end
            run_sw = 1'b1;
            frame_start = (c == 19);
            clk1();
        end
    endtask

    task automatic test_load();
        do_reset();
        for (int c = 0; c <= 35; c++) begin
            if (c == 30) begin
                n_cmp++; if (overrun !== 1'b1) begin n_bad++; $display("FAIL load_pre_overrun got %b want 1", overrun); end
                n_cmp++; if (gen_count !== 16'd1) begin n_bad++; $display("FAIL load_pre_gen got %0d want 1", gen_count); end
            end
            if (c == 31 || c == 32) begin
                n_cmp++; if (set_state !== 1'b1) begin n_bad++; $display("FAIL load_set_state c=%0d got %b want 1", c, set_state); end
                n_cmp++; if (sched_state !== 2'd2) begin n_bad++; $display("FAIL load_state c=%0d got %0d want 2", c, sched_state); end
                n_cmp++; if (gen_count !== 16'd0) begin n_bad++; $display("FAIL load_gen c=%0d got %0d want 0", c, gen_count); end
                n_cmp++; if (overrun !== 1'b0) begin n_bad++; $display("FAIL load_overrun c=%0d got %b want 0", c, overrun); end
            end
            if (c >= 31 && c <= 33) begin
                n_cmp++; if (evolve !== 1'b0) begin n_bad++; $display("FAIL load_evolve c=%0d got %b want 0", c, evolve); end
            end
            if (c == 33) begin
                n_cmp++; if (set_state !== 1'b0) begin n_bad++; $display("FAIL load_set_state_end got %b want 0", set_state); end
                n_cmp++; if (sched_state !== 2'd0) begin n_bad++; $display("FAIL load_exit_state got %0d want 0", sched_state); end
            end
            run_sw = 1'b1;
            frame_start = (c == 19 || c == 30);
            load_btn = (c == 30);
            clk1();
        end
        load_btn = 1'b0;
    endtask

    task automatic test_speed();
        do_reset();
        for (int c = 0; c <= 23; c++) begin
            if (c == 21 || c == 23) begin
                n_cmp++; if (evolve !== 1'b0) begin n_bad++; $display("FAIL speed_evolve_idle c=%0d got %b want 0", c, evolve); end
            end
            if (c == 22) begin
                n_cmp++; if (evolve !== 1'b1) begin n_bad++; $display("FAIL speed_evolve got %b want 1", evolve); end
                n_cmp++; if (gen_count !== 16'd1) begin n_bad++; $display("FAIL speed_gen got %0d want 1", gen_count); end
            end
            run_sw = 1'b1;
            speed = (c >= 21) ? 3'd0 : 3'd3;
            frame_start = (c == 20 || c == 21);
            clk1();
        end
    endtask

    task automatic test_reset_mid_load();
        do_reset();
        for (int c = 0; c <= 3; c++) begin
            run_sw = 1'b0;
            load_btn = (c == 2);
            clk1();
        end
        load_btn = 1'b0;
        n_cmp++; if (set_state !== 1'b1) begin n_bad++; $display("FAIL midload_set_state_pre got %b want 1", set_state); end
        step_btn = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++; if (set_state !== 1'b0) begin n_bad++; $display("FAIL midload_set_state got %b want 0", set_state); end
        n_cmp++; if (sched_state !== 2'd0) begin n_bad++; $display("FAIL midload_state got %0d want 0", sched_state); end
        n_cmp++; if (evolve !== 1'b0) begin n_bad++; $display("FAIL midload_evolve got %b want 0", evolve); end
        n_cmp++; if (gen_count !== 16'd0 || overrun !== 1'b0) begin
            n_bad++; $display("FAIL midload_gen_ovr got %0d/%b want 0/0", gen_count, overrun);
        end
        clk1();
        clk1();
        rst_n = 1'b1;
        for (int c = 0; c <= 37; c++) begin
            n_cmp++;
            if (evolve !== (c == 36)) begin
                n_bad++; $display("FAIL held_step_evolve c=%0d got %b want %b", c, evolve, (c == 36));
            end
            run_sw = 1'b0;
            step_btn = (c != 30);
            frame_start = (c == 10 || c == 25 || c == 35);
            clk1();
        end
        n_cmp++; if (gen_count !== 16'd1) begin n_bad++; $display("FAIL held_step_gen got %0d want 1", gen_count); end
    endtask

    initial begin
        test_reset();
        test_run();
        test_step();
        test_wrap();
        test_load();
        test_speed();
        test_reset_mid_load();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
